// File: rtl/interrupt_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: FSM encoding, register offsets, source limit.
// No logic of its own; imported by the arbiter, its selector and its interface.
package interrupt_arbiter_pkg;

    localparam int MAX_SOURCES = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam logic [7:0] OFS_PENDING = 8'd0;
    localparam logic [7:0] OFS_MASK    = 8'd1;
    localparam logic [7:0] OFS_VECTOR  = 8'd2;
    localparam logic [7:0] OFS_CLEAR   = 8'd3;

    function automatic logic [MAX_SOURCES-1:0] id_onehot(input logic [2:0] id);
        return MAX_SOURCES'(1) << id;
    endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Peripheral raise/ack lines and the processor request/acknowledge pair.
// master = arbiter side; slave = the peripherals plus processor driving it.
interface interrupt_arbiter_if #(
    parameter int NumSources = 4
);
    logic [NumSources-1:0] IRQ_IN;
    logic [NumSources-1:0] IRQ_ACK_OUT;
    logic                  CPU_INTERRUPT_RAISE;
    logic                  CPU_INTERRUPT_ACK;

    modport master (
        input  IRQ_IN,
        input  CPU_INTERRUPT_ACK,
        output IRQ_ACK_OUT,
        output CPU_INTERRUPT_RAISE
    );

    modport slave (
        output IRQ_IN,
        output CPU_INTERRUPT_ACK,
        input  IRQ_ACK_OUT,
        input  CPU_INTERRUPT_RAISE
    );
endinterface

// File: rtl/irq_priority_select.sv
// Combinational circular search: first set bit of elig starting at ptr+1, wrapping at NumSources.
// Zero latency; ptr = NumSources-1 gives plain lowest-index-first priority.
module irq_priority_select
    import interrupt_arbiter_pkg::*;
#(
    parameter int NumSources = 4
) (
    input  logic [MAX_SOURCES-1:0] elig,
    input  logic [2:0]             ptr,
    output logic [2:0]             id,
    output logic                   found
);

    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int k = 0; k < NumSources; k++) begin
            if (!found && elig[3'((int'(ptr) + 1 + k) % NumSources)]) begin
                found = 1'b1;
                id    = 3'((int'(ptr) + 1 + k) % NumSources);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Edge-latching, maskable interrupt arbiter on the 8-bit bus; raise 2 cycles after an edge, reads 1 cycle after address.
// One request at a time, held until CPU ack; INTERRUPT_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed priority.
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter logic [7:0] BaseAddr    = 8'hE0,
    parameter int         NumSources  = 4,
    parameter logic [7:0] InitialMask = 8'hFF
) (
    input  logic                CLK,
    input  logic                RESET,
    inout  wire  [7:0]          BUS_DATA,
    input  logic [7:0]          BUS_ADDR,
    input  logic                BUS_WE,
    interrupt_arbiter_if.master irq_if
);

    localparam logic [MAX_SOURCES-1:0] SRC_MASK = MAX_SOURCES'((9'd1 << NumSources) - 9'd1);

    logic [1:0]             state_q;
    logic [2:0]             active_id_q;
    logic [2:0]             sel_id;
    logic [2:0]             ptr;
    logic                   sel_found;
    logic [MAX_SOURCES-1:0] prev_q;
    logic [MAX_SOURCES-1:0] pending_q;
    logic [MAX_SOURCES-1:0] mask_q;
    logic [MAX_SOURCES-1:0] irq_ext;
    logic [MAX_SOURCES-1:0] edge_vec;
    logic [MAX_SOURCES-1:0] clr_vec;
    logic [MAX_SOURCES-1:0] elig;
    logic [NumSources-1:0]  ack_q;
    logic [7:0]             ofs;
    logic [7:0]             rd_val;
    logic [7:0]             rd_dat_q;
    logic                   rd_en_q;
    logic                   rd_hit;
    logic                   ack_take;

    // Internal vectors are MAX_SOURCES wide with unused upper bits held at zero.
    assign irq_ext  = MAX_SOURCES'(irq_if.IRQ_IN);
    assign edge_vec = irq_ext & ~prev_q;
    assign elig     = pending_q & mask_q;
    assign ofs      = BUS_ADDR - BaseAddr;
    assign ack_take = (state_q == ST_WAIT_ACK) && irq_if.CPU_INTERRUPT_ACK;
    assign rd_hit   = !BUS_WE && (ofs == OFS_PENDING || ofs == OFS_MASK || ofs == OFS_VECTOR);

    always_comb begin
        clr_vec = '0;
        if (BUS_WE && ofs == OFS_CLEAR) begin
            clr_vec = BUS_DATA & SRC_MASK;
        end
        if (ack_take) begin
            clr_vec = clr_vec | id_onehot(active_id_q);
        end
    end

    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_PENDING: rd_val = pending_q;
            OFS_MASK:    rd_val = mask_q;
            OFS_VECTOR:  rd_val = {state_q == ST_WAIT_ACK, 4'b0000, active_id_q};
            default:     rd_val = '0;
        endcase
    end

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
    logic [2:0] ptr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q <= 3'(NumSources - 1);
        end else if (state_q == ST_IDLE && sel_found) begin
            ptr_q <= sel_id;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 3'(NumSources - 1);
`endif

    irq_priority_select #(
        .NumSources (NumSources)
    ) u_sel (
        .elig  (elig),
        .ptr   (ptr),
        .id    (sel_id),
        .found (sel_found)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            active_id_q <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= InitialMask & SRC_MASK;
            ack_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            prev_q    <= irq_ext;
            // A new edge in the same cycle as a clear keeps the bit set.
            pending_q <= (pending_q & ~clr_vec) | edge_vec;
            if (BUS_WE && ofs == OFS_MASK) begin
                mask_q <= BUS_DATA & SRC_MASK;
            end
            rd_en_q  <= rd_hit;
            rd_dat_q <= rd_val;
            ack_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        active_id_q <= sel_id;
                        state_q     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (irq_if.CPU_INTERRUPT_ACK) begin
                        ack_q   <= NumSources'(id_onehot(active_id_q));
                        state_q <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    assign irq_if.CPU_INTERRUPT_RAISE = (state_q == ST_WAIT_ACK);
    assign irq_if.IRQ_ACK_OUT         = ack_q;
    assign BUS_DATA                   = rd_en_q ? rd_dat_q : 8'hzz;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle compared against a behavioural model of the arbiter.
module tb_interrupt_arbiter;

    localparam int NSRC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      addr;
    logic [7:0]      wdat;
    logic            we;
    logic [NSRC-1:0] irq;
    logic            cpu_ack;
    wire  [7:0]      bus_data;

    int n_checks = 0;
    int n_errors = 0;

    assign bus_data = we ? wdat : 8'hzz;

    interrupt_arbiter_if #(.NumSources(NSRC)) irq_if ();
    assign irq_if.IRQ_IN            = irq;
    assign irq_if.CPU_INTERRUPT_ACK = cpu_ack;

    interrupt_arbiter #(
        .BaseAddr    (8'hE0),
        .NumSources  (NSRC),
        .InitialMask (8'hFF)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_DATA (bus_data),
        .BUS_ADDR (addr),
        .BUS_WE   (we),
        .irq_if   (irq_if)
    );

    always #5 clk = ~clk;

    // Reference model: pending/mask as bit sets, one outstanding request, one cooldown cycle.
    logic [NSRC-1:0] m_pend   = '0;
    logic [NSRC-1:0] m_prev   = '0;
    logic [NSRC-1:0] m_mask   = '1;
    logic [NSRC-1:0] m_ack    = '0;
    bit              m_raise  = 1'b0;
    bit              m_cool   = 1'b0;
    int              m_id     = 0;
    int              m_last   = NSRC - 1;
    bit              m_rd_en  = 1'b0;
    logic [7:0]      m_rd_dat = '0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [NSRC-1:0] edges;
        logic [NSRC-1:0] clr;
        logic [7:0]      ofs;
        int              start;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_mask = '1; m_ack = '0;
            m_raise = 1'b0; m_cool = 1'b0; m_id = 0; m_last = NSRC - 1;
            m_rd_en = 1'b0;
            return;
        end
        edges   = irq & ~m_prev;
        ofs     = addr - 8'hE0;
        clr     = '0;
        m_rd_en = !we && ofs <= 8'd2;
        case (ofs)
            8'd0:    m_rd_dat = 8'(m_pend);
            8'd1:    m_rd_dat = 8'(m_mask);
            default: m_rd_dat = {m_raise, 4'b0000, 3'(m_id)};
        endcase
        if (we && ofs == 8'd3) clr = wdat[NSRC-1:0];
        m_ack = '0;
        if (m_raise) begin
            if (cpu_ack) begin
                clr[m_id]   = 1'b1;
                m_ack[m_id] = 1'b1;
                m_raise     = 1'b0;
                m_cool      = 1'b1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
            start = (m_last + 1) % NSRC;
`else
            start = 0;
`endif
            for (int k = 0; k < NSRC; k++) begin
                if (!m_raise && m_pend[(start + k) % NSRC] && m_mask[(start + k) % NSRC]) begin
                    m_raise = 1'b1;
                    m_id    = (start + k) % NSRC;
                end
            end
            if (m_raise) m_last = m_id;
        end
        m_pend = (m_pend & ~clr) | edges;
        m_prev = irq;
        if (we && ofs == 8'd1) m_mask = wdat[NSRC-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'(m_raise));
        check("ack_out", 8'(irq_if.IRQ_ACK_OUT), 8'(m_ack));
        if (m_rd_en) check("rd_data", bus_data, m_rd_dat);
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            cpu_ack = irq_if.CPU_INTERRUPT_RAISE;
            tick();
        end
        cpu_ack = 1'b0;
        tick();
    endtask

    initial begin
        int r;
        int w;
        rst = 1'b1; irq = '0; cpu_ack = 1'b0; addr = 8'h00; we = 1'b0; wdat = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        check("rst_ack", 8'(irq_if.IRQ_ACK_OUT), 8'h00);
        addr = 8'hE1; tick(); check("rst_mask", bus_data, 8'h0F);
        addr = 8'hE0; tick(); check("rst_pend", bus_data, 8'h00);
        addr = 8'hE2; tick(); check("rst_vec", bus_data, 8'h00);
        addr = 8'h00; tick();

        // Single source: latency, register reads, one-cycle ack pulse.
        irq[2] = 1'b1; tick();
        check("t1_no_raise_yet", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        addr = 8'hE0; tick();
        check("t1_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
        check("t1_rd_pend", bus_data, 8'h04);
        addr = 8'hE2; tick(); check("t1_vec", bus_data, 8'h82);
        addr = 8'h00; cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        check("t1_ack_pulse", 8'(irq_if.IRQ_ACK_OUT), 8'h04);
        check("t1_raise_drop", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        irq[2] = 1'b0; addr = 8'hE0; tick();
        check("t1_ack_once", 8'(irq_if.IRQ_ACK_OUT), 8'h00);
        check("t1_pend_clr", bus_data, 8'h00);
        addr = 8'h00; tick();

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        irq[0] = 1'b1; irq[1] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            w = 0;
            while (irq_if.CPU_INTERRUPT_RAISE !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) check("rr_wait", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
            addr = 8'hE2; tick();
            check("rr_order", bus_data, 8'h80 | 8'(s % 2));
            addr = 8'h00; cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
            irq[s % 2] = 1'b0; tick(); irq[s % 2] = 1'b1;
        end
        irq = '0;
        drain();
`else
        // Simultaneous sources 1 and 3: lowest index first, next only after cooldown.
        irq[1] = 1'b1; irq[3] = 1'b1; tick(); tick();
        check("t2_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
        addr = 8'hE2; tick(); check("t2_vec1", bus_data, 8'h81);
        addr = 8'h00; cpu_ack = 1'b1; tick(); cpu_ack = 1'b0; irq[1] = 1'b0;
        check("t2_ack1", 8'(irq_if.IRQ_ACK_OUT), 8'h02);
        tick(); check("t2_cooldown", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        tick(); check("t2_raise3", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
        addr = 8'hE2; tick(); check("t2_vec3", bus_data, 8'h83);
        addr = 8'h00; cpu_ack = 1'b1; tick(); cpu_ack = 1'b0; irq[3] = 1'b0;
        check("t2_ack3", 8'(irq_if.IRQ_ACK_OUT), 8'h08);
        drain();
`endif

        // Masked source stays pending and is serviced once unmasked.
        addr = 8'hE1; we = 1'b1; wdat = 8'hFE; tick(); we = 1'b0; addr = 8'h00;
        irq[0] = 1'b1; tick(); irq[0] = 1'b0; tick(); tick();
        check("t4_masked", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        addr = 8'hE0; tick(); check("t4_pend0", bus_data, 8'h01);
        addr = 8'h00; tick();
        addr = 8'hE1; we = 1'b1; wdat = 8'hFF; tick(); we = 1'b0; addr = 8'h00;
        check("t4_not_yet", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        tick(); check("t4_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
        drain();

        // W1C colliding with a new edge: the set wins.
        addr = 8'hE1; we = 1'b1; wdat = 8'h07; tick();
        addr = 8'hE3; wdat = 8'h08; irq[3] = 1'b1; tick();
        we = 1'b0; addr = 8'hE0; tick(); check("t5_set_wins", bus_data, 8'h08);
        addr = 8'h00; tick();
        addr = 8'hE3; we = 1'b1; wdat = 8'h08; tick();
        we = 1'b0; addr = 8'hE0; tick(); check("t5_w1c", bus_data, 8'h00);
        addr = 8'h00; tick();
        addr = 8'hE1; we = 1'b1; wdat = 8'hFF; tick(); we = 1'b0; addr = 8'h00; irq[3] = 1'b0;
        tick(); tick();
        check("t5_idle", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);

        // Reset in the middle of a handshake.
        irq[1] = 1'b1; tick(); tick();
        check("t6_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h01);
        rst = 1'b1; cpu_ack = 1'b1; tick(); rst = 1'b0; cpu_ack = 1'b0;
        check("t6_rst_raise", 8'(irq_if.CPU_INTERRUPT_RAISE), 8'h00);
        check("t6_rst_ack", 8'(irq_if.IRQ_ACK_OUT), 8'h00);
        addr = 8'hE1; tick();
        check("t6_no_ack", 8'(irq_if.IRQ_ACK_OUT), 8'h00);
        check("t6_mask", bus_data, 8'h0F);
        addr = 8'h00; irq[1] = 1'b0;
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (m_ack[i]) irq[i] = 1'b0;
                else if (!irq[i] && $urandom_range(7) == 0) irq[i] = 1'b1;
                else if (irq[i] && $urandom_range(63) == 0) irq[i] = 1'b0;
            end
            cpu_ack = m_raise ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            we   = 1'b0;
            wdat = 8'h00;
            r    = int'($urandom_range(19));
            if (!m_rd_en && r == 0) begin
                we = 1'b1; addr = 8'hE1; wdat = 8'($urandom);
            end else if (!m_rd_en && r == 1) begin
                we = 1'b1; addr = 8'hE3; wdat = 8'($urandom);
            end else if (r < 12) begin
                addr = 8'hE0 + 8'($urandom_range(3));
            end else begin
                addr = 8'($urandom);
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0; we = 1'b0; cpu_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
